// File: rtl/accel_bus_responder.sv
// accel_bus_responder
//   Accelerator-side responder on the CPU accelerator bus. Exposes an
//   8 x DATA_W register file over a shared tri-state data bus and, on a
//   start request, runs a signed multiply-accumulate loop into a
//   2*DATA_W-bit accumulator, then completes the start/done handshake.
//
// Ports
//   clk             : system clock, all state on the rising edge
//   rst_n           : synchronous active-low reset
//   bus_accel_en    : CPU bus transaction enable
//   bus_accel_start : CPU run request, held high until done is seen
//   bus_rdwr        : 2'b10 read, 2'b01 write, otherwise no access
//   bus_accregaddr  : register select
//   bus_data        : tri-state data bus (driven only during reads)
//   bus_accel_done  : operation complete, qualified by en & start
//
// Register map
//   0 CTRL (N = CTRL[CNT_W-1:0])  1 A  2 B  3 ACC_LO  4 ACC_HI
//   5 STATUS {wr_reject, done, busy} (read-only, write clears wr_reject)
//   6 CYCLES (read-only)          7 SCRATCH
module accel_bus_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_accel_en,
  input  logic              bus_accel_start,
  input  logic [1:0]        bus_rdwr,
  input  logic [ADDR_W-1:0] bus_accregaddr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              bus_accel_done
);

  localparam int ACC_W = 2 * DATA_W;

  localparam logic [ADDR_W-1:0] R_CTRL    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] R_A       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] R_B       = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] R_ACC_LO  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] R_ACC_HI  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] R_STATUS  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] R_CYCLES  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] R_SCRATCH = ADDR_W'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Full-width signed product; the sign extension of both operands makes
  // the truncated ACC_W-bit product exact for any DATA_W x DATA_W pair.
  function automatic logic signed [ACC_W-1:0] mac_product(
    input logic signed [DATA_W-1:0] op_a,
    input logic signed [DATA_W-1:0] op_b
  );
    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] b_ext;
    a_ext = {{DATA_W{op_a[DATA_W-1]}}, op_a};
    b_ext = {{DATA_W{op_b[DATA_W-1]}}, op_b};
    return a_ext * b_ext;
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         ctrl_q, ctrl_d;
  logic [DATA_W-1:0]         a_q, a_d;
  logic [DATA_W-1:0]         b_q, b_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [DATA_W-1:0]         cycles_q, cycles_d;
  logic [DATA_W-1:0]         scratch_q, scratch_d;
  logic                      wr_reject_q, wr_reject_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  a_snap_q, a_snap_d;
  logic signed [DATA_W-1:0]  b_snap_q, b_snap_d;

  logic              rd_access;
  logic              wr_access;
  logic              go;
  logic              lock;
  logic [DATA_W-1:0] rdata;

  assign rd_access = bus_accel_en & (bus_rdwr == 2'b10);
  assign wr_access = bus_accel_en & (bus_rdwr == 2'b01);
  assign go        = bus_accel_en & bus_accel_start;
  // Operand/control registers are frozen while an op is running or about to
  // be launched on this edge, so the snapshot and the MAC never see a torn value.
  assign lock      = (state_q != S_IDLE) | go;

  assign bus_accel_done = (state_q == S_DONE) & go;

  always_comb begin
    rdata = '0;
    case (bus_accregaddr)
      R_CTRL:    rdata = ctrl_q;
      R_A:       rdata = a_q;
      R_B:       rdata = b_q;
      R_ACC_LO:  rdata = acc_q[DATA_W-1:0];
      R_ACC_HI:  rdata = acc_q[ACC_W-1:DATA_W];
      R_STATUS:  rdata = {{(DATA_W-3){1'b0}}, wr_reject_q,
                          (state_q == S_DONE), (state_q == S_BUSY)};
      R_CYCLES:  rdata = cycles_q;
      R_SCRATCH: rdata = scratch_q;
      default:   rdata = '0;
    endcase
  end

  assign bus_data = rd_access ? rdata : {DATA_W{1'bz}};

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cycles_d    = cycles_q;
    scratch_d   = scratch_q;
    wr_reject_d = wr_reject_q;
    cnt_d       = cnt_q;
    a_snap_d    = a_snap_q;
    b_snap_d    = b_snap_q;

    if (wr_access) begin
      case (bus_accregaddr)
        R_CTRL:    if (lock) wr_reject_d = 1'b1; else ctrl_d = bus_data;
        R_A:       if (lock) wr_reject_d = 1'b1; else a_d = bus_data;
        R_B:       if (lock) wr_reject_d = 1'b1; else b_d = bus_data;
        R_ACC_LO:  if (lock) wr_reject_d = 1'b1; else acc_d[DATA_W-1:0] = bus_data;
        R_ACC_HI:  if (lock) wr_reject_d = 1'b1; else acc_d[ACC_W-1:DATA_W] = bus_data;
        R_STATUS:  wr_reject_d = 1'b0;
        R_SCRATCH: scratch_d = bus_data;
        default:   ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d  = S_BUSY;
          cnt_d    = ctrl_q[CNT_W-1:0];
          cycles_d = '0;
          a_snap_d = a_q;
          b_snap_d = b_q;
        end
      end
      S_BUSY: begin
        if (!go) begin
          // Abort: partial ACC/CYCLES remain visible to software.
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          acc_d    = acc_q + mac_product(a_snap_q, b_snap_q);
          cnt_d    = cnt_q - 1'b1;
          cycles_d = sat_inc(cycles_q);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cycles_q    <= '0;
      scratch_q   <= '0;
      wr_reject_q <= 1'b0;
      cnt_q       <= '0;
      a_snap_q    <= '0;
      b_snap_q    <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cycles_q    <= cycles_d;
      scratch_q   <= scratch_d;
      wr_reject_q <= wr_reject_d;
      cnt_q       <= cnt_d;
      a_snap_q    <= a_snap_d;
      b_snap_q    <= b_snap_d;
    end
  end

endmodule

// File: tb/tb_accel_bus_responder.sv
// Testbench for accel_bus_responder: register table, hand-written handshake
// sequences, and randomized MAC operations against an arithmetic model.
module tb_accel_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [1:0]  rdwr;
  logic [2:0]  addr;
  logic        done;
  logic        drv_en;
  logic [15:0] drv_val;
  wire  [15:0] bus_data;

  int checks   = 0;
  int failures = 0;

  assign bus_data = drv_en ? drv_val : 16'hzzzz;
  pullup (bus_data);

  always #5 clk = ~clk;

  accel_bus_responder #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_accel_en   (en),
    .bus_accel_start(start),
    .bus_rdwr       (rdwr),
    .bus_accregaddr (addr),
    .bus_data       (bus_data),
    .bus_accel_done (done)
  );

  typedef struct {
    logic [2:0]  a;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Nobody should be driving: the net floats (z) or sits at the pull-up level.
  task automatic chk_undriven(input string name);
    checks++;
    if (!((bus_data === 16'hzzzz) || (bus_data === 16'hffff))) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=undriven", name, bus_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    addr    = a;
    rdwr    = 2'b01;
    drv_val = d;
    drv_en  = 1'b1;
    tick();
    rdwr    = 2'b00;
    drv_en  = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a;
    rdwr = 2'b10;
    #1;
    d    = bus_data;
    rdwr = 2'b00;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    chk(name, {16'h0, d}, {16'h0, exp});
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    start  = 1'b0;
    rdwr   = 2'b00;
    addr   = 3'd0;
    drv_en = 1'b0;
    drv_val = 16'h0;
    tick();
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  // Start an op, wait (bounded) for done, confirm it holds, then release.
  task automatic run_op(input int n);
    int lat;
    int exp_lat;
    exp_lat = (n == 0) ? 1 : n;
    start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 600) begin
      tick();
      lat++;
    end
    chk("op_latency", lat, exp_lat);
    tick();
    chk("done_held", {31'h0, done}, 32'h1);
    start = 1'b0;
    #1;
    chk("done_drops_with_start", {31'h0, done}, 32'h0);
    tick();
  endtask

  // Start an op and drop start after k MAC cycles; done must never rise.
  task automatic abort_op(input int k);
    logic seen;
    seen  = 1'b0;
    start = 1'b1;
    tick();
    for (int i = 0; i < k; i++) begin
      seen = seen | done;
      tick();
    end
    seen  = seen | done;
    start = 1'b0;
    #1;
    seen  = seen | done;
    tick();
    chk("abort_no_done", {31'h0, seen}, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb, rscr;
    logic [31:0] acc_m;
    int          n, k;
    longint      prod;

    tbl[0] = '{3'd0, 16'h00AB, 16'h00AB};
    tbl[1] = '{3'd1, 16'h1234, 16'h1234};
    tbl[2] = '{3'd2, 16'h8001, 16'h8001};
    tbl[3] = '{3'd3, 16'hBEEF, 16'hBEEF};
    tbl[4] = '{3'd4, 16'hCAFE, 16'hCAFE};
    tbl[5] = '{3'd5, 16'hFFFF, 16'h0000};
    tbl[6] = '{3'd6, 16'h5555, 16'h0000};
    tbl[7] = '{3'd7, 16'hA5A5, 16'hA5A5};

    // Reset state
    do_reset();
    en = 1'b0;
    @(negedge clk);
    rdwr = 2'b10;
    #1;
    chk_undriven("no_drive_when_en_low");
    chk("done_after_reset", {31'h0, done}, 32'h0);
    rdwr = 2'b11;
    en   = 1'b1;
    addr = 3'd7;
    #1;
    chk_undriven("no_drive_rdwr11");
    rdwr = 2'b00;
    #1;
    chk_undriven("no_drive_idle_bus");
    for (int i = 0; i < 8; i++) chk_reg($sformatf("reset_r%0d", i), 3'(i), 16'h0000);

    // Table: write every register, read everything back
    foreach (tbl[i]) bus_write(tbl[i].a, tbl[i].wdata);
    foreach (tbl[i]) chk_reg($sformatf("table_r%0d", i), tbl[i].a, tbl[i].exp);

    // rdwr=11 must not write
    addr = 3'd7; rdwr = 2'b11; drv_val = 16'h1111; drv_en = 1'b1;
    tick();
    rdwr = 2'b00; drv_en = 1'b0;
    chk_reg("rdwr11_no_write", 3'd7, 16'hA5A5);
    chk_reg("rdwr11_no_reject", 3'd5, 16'h0000);

    // Basic op: 3 * -2 accumulated 4 times
    bus_write(3'd1, 16'h0003);
    bus_write(3'd2, 16'hFFFE);
    bus_write(3'd0, 16'h0004);
    bus_write(3'd3, 16'h0000);
    bus_write(3'd4, 16'h0000);
    run_op(4);
    chk_reg("op2_status_idle", 3'd5, 16'h0000);
    chk_reg("op2_acc_hi", 3'd4, 16'hFFFF);
    chk_reg("op2_acc_lo", 3'd3, 16'hFFE8);
    chk_reg("op2_cycles", 3'd6, 16'h0004);

    // N=0: done after one cycle, ACC untouched
    bus_write(3'd0, 16'h0000);
    run_op(0);
    chk_reg("n0_acc_lo", 3'd3, 16'hFFE8);
    chk_reg("n0_acc_hi", 3'd4, 16'hFFFF);
    chk_reg("n0_cycles", 3'd6, 16'h0000);

    // Rejected write during BUSY, then clear the sticky flag
    bus_write(3'd0, 16'h000A);
    start = 1'b1;
    tick();
    bus_write(3'd1, 16'h1111);
    chk_reg("busy_a_unchanged", 3'd1, 16'h0003);
    chk_reg("busy_status_reject", 3'd5, 16'h0005);
    bus_write(3'd7, 16'h7777);
    chk_reg("busy_scratch_writable", 3'd7, 16'h7777);
    bus_write(3'd5, 16'h0000);
    chk_reg("busy_reject_cleared", 3'd5, 16'h0001);
    start = 1'b0;
    tick();
    chk_reg("abort_to_idle", 3'd5, 16'h0000);

    // Write rejected in IDLE on the edge that samples start
    bus_write(3'd0, 16'h0002);
    start = 1'b1;
    bus_write(3'd2, 16'h4444);
    start = 1'b0;
    tick();
    chk_reg("start_edge_b_unchanged", 3'd2, 16'hFFFE);
    chk_reg("start_edge_reject", 3'd5, 16'h0004);
    bus_write(3'd5, 16'h0000);

    // Abort after two MAC cycles
    bus_write(3'd3, 16'h0000);
    bus_write(3'd4, 16'h0000);
    bus_write(3'd1, 16'h0001);
    bus_write(3'd2, 16'h0001);
    bus_write(3'd0, 16'h000A);
    abort_op(2);
    chk_reg("abort_status", 3'd5, 16'h0000);
    chk_reg("abort_acc_lo", 3'd3, 16'h0002);
    chk_reg("abort_cycles", 3'd6, 16'h0002);

    // Max-magnitude products, N=255, wrap modulo 2^32
    bus_write(3'd1, 16'h7FFF);
    bus_write(3'd2, 16'h7FFF);
    bus_write(3'd0, 16'h00FF);
    bus_write(3'd3, 16'h0000);
    bus_write(3'd4, 16'h0000);
    run_op(255);
    chk_reg("big_acc_hi", 3'd4, 16'hBF01);
    chk_reg("big_acc_lo", 3'd3, 16'h00FF);
    chk_reg("big_cycles", 3'd6, 16'h00FF);

    // Reset pulsed mid-BUSY
    bus_write(3'd1, 16'h0003);
    bus_write(3'd2, 16'hFFFE);
    bus_write(3'd0, 16'h0004);
    start = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("reset_done_low", {31'h0, done}, 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) chk_reg($sformatf("midreset_r%0d", i), 3'(i), 16'h0000);
    en = 1'b0;
    @(negedge clk);
    rdwr = 2'b10;
    #1;
    chk_undriven("midreset_bus_z");
    rdwr = 2'b00;
    en   = 1'b1;

    // Randomized ops against an arithmetic model
    for (int it = 0; it < 20; it++) begin
      ra    = 16'($urandom);
      rb    = 16'($urandom);
      rscr  = 16'($urandom);
      acc_m = $urandom;
      n     = $urandom_range(0, 12);
      k     = n;
      if (n >= 2 && $urandom_range(0, 3) == 0) k = $urandom_range(1, n - 1);
      bus_write(3'd1, ra);
      bus_write(3'd2, rb);
      bus_write(3'd0, {8'($urandom), 8'(n)});
      bus_write(3'd3, acc_m[15:0]);
      bus_write(3'd4, acc_m[31:16]);
      bus_write(3'd7, rscr);
      prod  = longint'($signed(ra)) * longint'($signed(rb));
      acc_m = acc_m + 32'(longint'(k) * prod);
      if (k < n) abort_op(k);
      else       run_op(n);
      chk_reg("rnd_acc_lo", 3'd3, acc_m[15:0]);
      chk_reg("rnd_acc_hi", 3'd4, acc_m[31:16]);
      chk_reg("rnd_cycles", 3'd6, 16'(k));
      chk_reg("rnd_a_kept", 3'd1, ra);
      chk_reg("rnd_scratch", 3'd7, rscr);
      chk_reg("rnd_status", 3'd5, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
